// File: rtl/fifo_stream_checker_if.sv
// FIFO read-port handshake between the stream checker (master) and the FIFO (slave).
// The checker raises r_trigger; the FIFO answers with r_data qualified by a one-cycle r_done.
interface fifo_stream_checker_if #(
    parameter int W = 16
);
    logic         r_trigger;
    logic [W-1:0] r_data;
    logic         r_done;

    modport master (
        output r_trigger,
        input  r_data,
        input  r_done
    );

    modport slave (
        input  r_trigger,
        output r_data,
        output r_done
    );
endinterface

// File: rtl/fifo_stream_checker.sv
// Drains a FIFO read port and checks that the words form an incrementing sequence.
// Define FIFO_STREAM_CHECKER_STALL_EN to gate r_trigger with an LFSR bit for backpressure tests.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | not reading; counters, err, bad_data and expected hold
// SYNC  | reading; next accepted word seeds expected, no check
// CHECK | reading; every accepted word compared against expected
// HALT  | stopped after a mismatch (STOP_ON_ERR=1); only rst leaves it
module fifo_stream_checker #(
    parameter int W           = 16,
    parameter int BANK_WORDS  = 128,
    parameter int SEED_FIRST  = 1,
    parameter int STOP_ON_ERR = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    fifo_stream_checker_if.master rd_if,
    output logic                  err_o,
    output logic [15:0]           err_count_o,
    output logic [31:0]           word_count_o,
    output logic                  bank_done_o,
    output logic [W-1:0]          bad_data_o,
    output logic [W-1:0]          expected_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        CHECK = 2'd2,
        HALT  = 2'd3
    } state_e;

    localparam int            CW        = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
    localparam logic [CW-1:0] BANK_LAST = CW'(BANK_WORDS - 1);

    state_e         state_q, state_d;
    logic           r_trigger_q, r_trigger_d;
    logic           err_q, err_d;
    logic [15:0]    err_count_q, err_count_d;
    logic [31:0]    word_count_q, word_count_d;
    logic           bank_done_q, bank_done_d;
    logic [W-1:0]   bad_data_q, bad_data_d;
    logic [W-1:0]   expected_q, expected_d;
    logic [CW-1:0]  bank_cnt_q, bank_cnt_d;

    logic           active;
    logic           accept;
    logic           match;

    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        err_count_d  = err_count_q;
        word_count_d = word_count_q;
        bank_done_d  = 1'b0;
        bad_data_d   = bad_data_q;
        expected_d   = expected_q;
        bank_cnt_d   = bank_cnt_q;

        active = (state_q == SYNC) || (state_q == CHECK);
        accept = active && rd_if.r_done;
        match  = (rd_if.r_data == expected_q);

        case (state_q)
            IDLE: begin
                if (en_i) begin
                    bank_cnt_d = '0;
                    if (SEED_FIRST != 0) begin
                        state_d = SYNC;
                    end else begin
                        state_d    = CHECK;
                        expected_d = '0;
                    end
                end
            end
            SYNC: begin
                if (!en_i) begin
                    state_d = IDLE;
                end else if (accept) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // A halting mismatch wins over a simultaneous en drop.
                if (accept && !match && (STOP_ON_ERR != 0)) begin
                    state_d = HALT;
                end else if (!en_i) begin
                    state_d = IDLE;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            word_count_d = word_count_q + 32'd1;
            bank_done_d  = (bank_cnt_q == BANK_LAST);
            bank_cnt_d   = bank_done_d ? '0 : bank_cnt_q + CW'(1);
            // Seed, match and resync all leave expected one past the word just seen.
            expected_d   = rd_if.r_data + W'(1);
            if ((state_q == CHECK) && !match) begin
                err_d = 1'b1;
                if (err_count_q != 16'hFFFF) begin
                    err_count_d = err_count_q + 16'd1;
                end
                if (!err_q) begin
                    bad_data_d = rd_if.r_data;
                end
            end
        end

        r_trigger_d = (state_d == SYNC) || (state_d == CHECK);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            r_trigger_q  <= 1'b0;
            err_q        <= 1'b0;
            err_count_q  <= '0;
            word_count_q <= '0;
            bank_done_q  <= 1'b0;
            bad_data_q   <= '0;
            expected_q   <= '0;
            bank_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            r_trigger_q  <= r_trigger_d;
            err_q        <= err_d;
            err_count_q  <= err_count_d;
            word_count_q <= word_count_d;
            bank_done_q  <= bank_done_d;
            bad_data_q   <= bad_data_d;
            expected_q   <= expected_d;
            bank_cnt_q   <= bank_cnt_d;
        end
    end

`ifdef FIFO_STREAM_CHECKER_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci taps 16,14,13,11, shifting toward the MSB.
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rd_if.r_trigger = r_trigger_q & lfsr_q[0];
`else
    assign rd_if.r_trigger = r_trigger_q;
`endif

    assign err_o        = err_q;
    assign err_count_o  = err_count_q;
    assign word_count_o = word_count_q;
    assign bank_done_o  = bank_done_q;
    assign bad_data_o   = bad_data_q;
    assign expected_o   = expected_q;

endmodule

// File: tb/tb_fifo_stream_checker.sv
// Scoreboard bench for fifo_stream_checker: a driver queues hand-computed results per word,
// a monitor pops them after each accepted word; a second instance covers HALT and bank wrap.
module tb_fifo_stream_checker;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic en   = 1'b0;
    logic en_h = 1'b0;

    always #5 clk = ~clk;

    fifo_stream_checker_if #(.W(16)) bus ();
    fifo_stream_checker_if #(.W(16)) bus_h ();

    logic        err, bd, err_h, bd_h;
    logic [15:0] errc, bad, expd, errc_h, bad_h, expd_h;
    logic [31:0] wcnt, wcnt_h;

    fifo_stream_checker #(.W(16), .BANK_WORDS(128), .SEED_FIRST(1), .STOP_ON_ERR(0)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .rd_if        (bus),
        .err_o        (err),
        .err_count_o  (errc),
        .word_count_o (wcnt),
        .bank_done_o  (bd),
        .bad_data_o   (bad),
        .expected_o   (expd)
    );

    fifo_stream_checker #(.W(16), .BANK_WORDS(4), .SEED_FIRST(0), .STOP_ON_ERR(1)) dut_h (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en_h),
        .rd_if        (bus_h),
        .err_o        (err_h),
        .err_count_o  (errc_h),
        .word_count_o (wcnt_h),
        .bank_done_o  (bd_h),
        .bad_data_o   (bad_h),
        .expected_o   (expd_h)
    );

    typedef struct {
        logic [15:0] expd;
        logic        err;
        logic [15:0] errc;
        logic [31:0] wc;
        logic [15:0] bad;
        logic        bd;
    } item_t;

    item_t       sbq[$];
    item_t       mon_it;
    logic [31:0] wc_m = 32'd0;
    logic        acc_seen = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          stall_lows = 0;
    bit          stall_win = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) acc_seen <= bus.r_done && bus.r_trigger && !rst;

    always @(negedge clk) begin
        if (stall_win && !bus.r_trigger) stall_lows++;
        if (acc_seen) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_accept: got word_count 0x%0h, want no accept", wcnt);
            end else begin
                mon_it = sbq.pop_front();
                chk("sb_expected",   32'(expd), 32'(mon_it.expd));
                chk("sb_err",        32'(err),  32'(mon_it.err));
                chk("sb_err_count",  32'(errc), 32'(mon_it.errc));
                chk("sb_word_count", wcnt,      mon_it.wc);
                chk("sb_bad_data",   32'(bad),  32'(mon_it.bad));
                chk("sb_bank_done",  32'(bd),   32'(mon_it.bd));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_word(input logic [15:0] d, input logic [15:0] e_exp, input logic e_err,
                             input logic [15:0] e_errc, input logic [15:0] e_bad,
                             input logic e_bd, input bit drop_en);
        int n = 0;
        while (bus.r_trigger !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.r_trigger !== 1'b1) begin
            chk("trigger_timeout", 32'(bus.r_trigger), 32'd1);
            return;
        end
        bus.r_data = d;
        bus.r_done = 1'b1;
        if (drop_en) en = 1'b0;
        wc_m++;
        sbq.push_back('{e_exp, e_err, e_errc, wc_m, e_bad, e_bd});
        @(posedge clk);
        @(negedge clk);
        bus.r_done = 1'b0;
    endtask

    task automatic reenable(input logic [15:0] held_exp);
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("trig_low_after_en_drop", 32'(bus.r_trigger), 32'd0);
        chk("expected_held_in_idle",  32'(expd), 32'(held_exp));
        chk("word_count_held",        wcnt, wc_m);
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
`ifndef FIFO_STREAM_CHECKER_STALL_EN
        chk("trig_high_after_en", 32'(bus.r_trigger), 32'd1);
`endif
    endtask

    task automatic chk_reset_vals();
        chk("rst_trigger",    32'(bus.r_trigger), 32'd0);
        chk("rst_err",        32'(err),  32'd0);
        chk("rst_err_count",  32'(errc), 32'd0);
        chk("rst_word_count", wcnt,      32'd0);
        chk("rst_bank_done",  32'(bd),   32'd0);
        chk("rst_bad_data",   32'(bad),  32'd0);
        chk("rst_expected",   32'(expd), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, want finish within 30000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.r_done   = 1'b0;
        bus.r_data   = 16'd0;
        bus_h.r_done = 1'b0;
        bus_h.r_data = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals();

        en = 1'b1;
        chk("trig_before_rise", 32'(bus.r_trigger), 32'd0);
        @(posedge clk);
        @(negedge clk);
`ifndef FIFO_STREAM_CHECKER_STALL_EN
        chk("trig_rise", 32'(bus.r_trigger), 32'd1);
`endif

        // Full bank 0x0005..0x0084, bank_done only after the 128th word.
        for (int i = 0; i < 128; i++)
            send_word(16'(5 + i), 16'(6 + i), 1'b0, 16'd0, 16'd0, (i == 127), 1'b0);
        @(negedge clk);
        chk("bank_done_one_cycle", 32'(bd), 32'd0);
        chk("bank_word_count",     wcnt,    32'd128);

        // Wrap of the data value through 0xFFFF.
        reenable(16'h0085);
        send_word(16'hFFFE, 16'hFFFF, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        send_word(16'hFFFF, 16'h0000, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        send_word(16'h0000, 16'h0001, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);

        // Mismatch on 7, resync passes 8; 8 arrives on the en-drop cycle.
        reenable(16'h0001);
        send_word(16'd1, 16'd2, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        send_word(16'd2, 16'd3, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        send_word(16'd7, 16'd8, 1'b1, 16'd1, 16'd7, 1'b0, 1'b0);
        send_word(16'd8, 16'd9, 1'b1, 16'd1, 16'd7, 1'b0, 1'b1);
        chk("trig_low_after_last_word", 32'(bus.r_trigger), 32'd0);

        // Second mismatch keeps the first bad_data.
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        send_word(16'd20, 16'd21, 1'b1, 16'd1, 16'd7, 1'b0, 1'b0);
        send_word(16'd30, 16'd31, 1'b1, 16'd2, 16'd7, 1'b0, 1'b0);

        // Mid-bank reset with err set and a valid word on the reset edge.
        for (int i = 0; i < 60; i++)
            send_word(16'(31 + i), 16'(32 + i), 1'b1, 16'd2, 16'd7, 1'b0, 1'b0);
        rst        = 1'b1;
        bus.r_data = 16'd91;
        bus.r_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst        = 1'b0;
        bus.r_done = 1'b0;
        wc_m       = 32'd0;
        chk_reset_vals();
        @(negedge clk);
        chk("no_bank_done_after_rst", 32'(bd), 32'd0);
        en = 1'b0;
        @(negedge clk);

        // STOP_ON_ERR instance: SEED_FIRST=0, 4-word banks, then halt.
        en_h = 1'b1;
        @(posedge clk);
        @(negedge clk);
`ifndef FIFO_STREAM_CHECKER_STALL_EN
        chk("h_trig_rise", 32'(bus_h.r_trigger), 32'd1);
`endif
        for (int k = 0; k < 10; k++) begin
            for (int n = 0; n < 40 && bus_h.r_trigger !== 1'b1; n++) @(negedge clk);
            bus_h.r_data = (k == 9) ? 16'd50 : 16'(k);
            bus_h.r_done = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus_h.r_done = 1'b0;
            if (k < 9) begin
                chk("h_expected",   32'(expd_h), 32'(k + 1));
                chk("h_word_count", wcnt_h,      32'(k + 1));
                chk("h_bank_done",  32'(bd_h),   32'((k == 3) || (k == 7)));
                chk("h_err_clean",  32'(err_h),  32'd0);
            end
        end
        chk("h_err",         32'(err_h),  32'd1);
        chk("h_err_count",   32'(errc_h), 32'd1);
        chk("h_bad_data",    32'(bad_h),  32'd50);
        chk("h_expected",    32'(expd_h), 32'd51);
        chk("h_trig_halted", 32'(bus_h.r_trigger), 32'd0);
        for (int k = 0; k < 3; k++) begin
            bus_h.r_data = 16'd51;
            bus_h.r_done = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus_h.r_done = 1'b0;
            chk("h_halt_word_count", wcnt_h, 32'd10);
        end
        chk("h_halt_err_count", 32'(errc_h), 32'd1);
        en_h = 1'b0;
        @(posedge clk);
        @(negedge clk);
        en_h = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("h_halt_sticky", 32'(bus_h.r_trigger), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        en_h = 1'b0;
        chk("h_rst_trigger",    32'(bus_h.r_trigger), 32'd0);
        chk("h_rst_word_count", wcnt_h,               32'd0);
        chk("h_rst_err",        32'(err_h),           32'd0);

`ifdef FIFO_STREAM_CHECKER_STALL_EN
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stall_win = 1'b1;
        for (int k = 0; k < 500; k++)
            send_word(16'(k), 16'(k + 1), 1'b0, 16'd0, 16'd0, (k % 128 == 127), 1'b0);
        stall_win = 1'b0;
        chk("stall_trigger_low_seen", 32'(stall_lows > 0), 32'd1);
        chk("stall_err",              32'(err),            32'd0);
        en = 1'b0;
`endif

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_stream_checker.md
FIFO_STREAM_CHECKER -- requirements
Module: fifo_stream_checker

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 Parameter W SHALL default to 16 and set the data width.
REQ-003 Parameter BANK_WORDS SHALL default to 128 and set the words per bank, a power of two.
REQ-004 Parameter SEED_FIRST SHALL default to 1; 1 means the first word seeds the expected value, 0 means expected starts at 0.
REQ-005 Parameter STOP_ON_ERR SHALL default to 0; 1 means the block halts on the first mismatch.
REQ-006 clk: input, 1 bit, the single clock.
REQ-007 rst: input, 1 bit, synchronous active-high reset.
REQ-008 en: input, 1 bit, level; high means consume and check words.
REQ-009 r_trigger: output, 1 bit, read request to the FIFO read port.
REQ-010 r_data: input, W bits, read data; valid only when r_done=1.
REQ-011 r_done: input, 1 bit, high for one cycle per word transferred.
REQ-012 err: output, 1 bit, sticky mismatch flag.
REQ-013 err_count: output, 16 bits, number of mismatches; saturates at 16'hFFFF.
REQ-014 word_count: output, 32 bits, number of words accepted; wraps modulo 2^32.
REQ-015 bank_done: output, 1 bit, one-cycle pulse at the end of each bank.
REQ-016 bad_data: output, W bits, the first mismatching word received.
REQ-017 expected: output, W bits, the value the next word must equal.

Function
REQ-018 The states SHALL be IDLE, SYNC, CHECK and HALT, with IDLE as the reset state.
REQ-019 IDLE SHALL go to SYNC (SEED_FIRST=1) or CHECK (SEED_FIRST=0, expected=0) on the cycle after en is sampled high.
REQ-020 r_trigger SHALL be registered and equal 1 exactly when the state is SYNC or CHECK, so it rises one cycle after en rises.
REQ-021 A word SHALL be accepted on every cycle with r_done=1 while in SYNC or CHECK; r_done in IDLE or HALT SHALL be ignored.
REQ-022 In SYNC, the accepted word SHALL set expected to r_data+1 (mod 2^W), increment word_count, skip the check, and move to CHECK.
REQ-023 In CHECK, an accepted word equal to expected SHALL set expected to expected+1 (mod 2^W), so 16'hFFFF is followed by 16'h0000.
REQ-024 In CHECK, a mismatch SHALL, on the next edge: set err; increment err_count (saturating); set expected to r_data+1 to resync; capture bad_data only when err was 0.
REQ-025 On a mismatch with STOP_ON_ERR=1, the state SHALL go to HALT, and r_trigger SHALL be 0 from the next cycle until rst.
REQ-026 Every accepted word, including the seeding word, SHALL increment word_count and the internal bank counter.
REQ-027 bank_done SHALL pulse on the cycle after the accepted word that brings the bank counter to BANK_WORDS; the bank counter then wraps to 0.
REQ-028 en sampled low in SYNC or CHECK SHALL return the state to IDLE, with r_trigger low the next cycle.
REQ-029 A word accepted on that same cycle SHALL still be checked.
REQ-030 On return to IDLE, counters, err, bad_data and expected SHALL hold their values.
REQ-031 Re-asserting en after IDLE SHALL reseed per SEED_FIRST; the bank counter SHALL reset to 0 on each IDLE exit.

Reset
REQ-032 rst SHALL take priority over every other input on the same edge.
REQ-033 rst SHALL force state IDLE, r_trigger=0, err=0, err_count=0, word_count=0, bank_done=0, bad_data=0, expected=0 and bank counter=0.
REQ-034 rst asserted mid-bank or in HALT SHALL abandon the bank without a bank_done pulse.

Configuration
REQ-035 With macro FIFO_STREAM_CHECKER_STALL_EN defined, r_trigger SHALL additionally be ANDed with bit 0 of a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on rst; advancing every cycle) to exercise FIFO backpressure.
REQ-036 Without FIFO_STREAM_CHECKER_STALL_EN, the LFSR SHALL be absent and r_trigger SHALL follow REQ-020 exactly.

Verification
REQ-037 Scenario: SEED_FIRST=1, en=1, feed 16'h0005..16'h0084 (128 words) -> err=0; word_count=128; one bank_done pulse after the 128th word; expected=16'h0085.
REQ-038 Scenario: feed 16'hFFFE, 16'hFFFF, 16'h0000 -> no error; expected=16'h0001.
REQ-039 Scenario: feed 1, 2, 7, 8 -> err=1 one cycle after 7 is accepted; err_count=1; bad_data=7; word 8 passes; expected=9.
REQ-040 Scenario: STOP_ON_ERR=1, mismatch injected -> state HALT; r_trigger=0 from the next cycle; later r_done pulses leave word_count unchanged.
REQ-041 Scenario: rst pulsed after 60 words with err=1 -> all outputs return to their reset values; no bank_done pulse.
REQ-042 Scenario: FIFO_STREAM_CHECKER_STALL_EN defined, 1000 cycles with en=1 -> r_trigger low on some cycles; err=0 against a FIFO fed an incrementing stream.
